// File: rtl/cla_seq_adder_ctrl_if.sv
// Handshake and data bus between a requesting datapath and cla_seq_adder_ctrl.
// Optional macro CLA_SEQ_SUB_EN adds the 'sub' request bit.
interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  // Requester side: issues operands and consumes the result.
  modport master (
    output in_valid, a, b, cin,
`ifdef CLA_SEQ_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  // Controller side.
  modport slave (
    input  in_valid, a, b, cin,
`ifdef CLA_SEQ_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder built on a single shared 4-bit CLA slice.
// One slice per clock, LSB slice first, carry chained through a register.
// Optional macro CLA_SEQ_SUB_EN: adds a 'sub' request bit (a - b).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready high, waiting for in_valid
// RUN   | one 4-bit slice per cycle, index 0..NSLICE-1
// DONE  | out_valid high, sum/cout held until out_ready

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Two-level lookahead carries for the 4-bit group.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c[3:0];
    co   = c[4];
  end
endmodule

module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  cla_seq_adder_ctrl_if.slave    bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
      $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             in_ready_r;

  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic [3:0]       sl_s;
  logic             sl_co;

  // Mux the current slice of the operand registers onto the shared CLA.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IW'(i)) begin
        sl_a = a_reg[4*i +: 4];
        sl_b = b_reg[4*i +: 4];
      end
    end
  end

  cla4 u_cla4 (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
  );

  // Controller FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
`ifdef CLA_SEQ_SUB_EN
            // Subtract as a + ~b + 1; cin is ignored for subtraction.
            b_reg <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
`else
            b_reg <= bus.b;
            carry <= bus.cin;
`endif
            idx        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx == IW'(i)) sum_r[4*i +: 4] <= sl_s;
          end
          carry <= sl_co;
          if (idx == IW'(NSLICE - 1)) begin
            // Index is left at the last slice so it never wraps.
            cout_r      <= sl_co;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // in_ready stays low here, so a new op waits for IDLE.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.busy      = busy_r;

endmodule
